// File: rtl/num_display_7seg.sv
// num_display_7seg: 8-bit value to decimal via serial double dabble, shown on a 4-digit
// common-anode seven-segment display with time-multiplexed digit scan.
module num_display_7seg #(
    parameter int REFRESH_DIV = 100_000,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  num,
    output logic [11:0] bcd,
    output logic        bcd_vld,
    output logic        busy,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        dp
);
    localparam int RW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t        state, state_nx;
    logic [19:0]   sh, adj, sh_nx;
    logic [2:0]    cnt;
    logic [7:0]    num_q;
    logic          pending;
    logic [RW-1:0] rcnt;
    logic [1:0]    idx;
    logic          wrap, blank_h, blank_t, lit;
    logic [3:0]    digit, an_nx;
    logic [6:0]    seg_nx;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'h7F;
        endcase
    endfunction

    always_comb begin
        adj = sh;
        for (int i = 0; i < 3; i++)
            if (sh[8+4*i +: 4] >= 4'd5) adj[8+4*i +: 4] = sh[8+4*i +: 4] + 4'd3;
        sh_nx = adj << 1;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = pending ? LOAD : IDLE;
            LOAD:    state_nx = SHIFT;
            SHIFT:   state_nx = (cnt == 3'd7) ? DONE : SHIFT;
            default: state_nx = IDLE;
        endcase
    end

    // The last shift writes bcd directly so the result lands on the same edge as DONE entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sh      <= '0;
            cnt     <= '0;
            num_q   <= '0;
            pending <= 1'b1;
            bcd     <= '0;
            bcd_vld <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            num_q   <= num;
            pending <= (num != num_q) | (pending & (state != IDLE));
            busy    <= (state_nx == LOAD) | (state_nx == SHIFT);
            bcd_vld <= (state == SHIFT) & (cnt == 3'd7);
            if (state == LOAD) begin
                sh  <= {12'd0, num};
                cnt <= '0;
            end
            if (state == SHIFT) begin
                sh  <= sh_nx;
                cnt <= cnt + 3'd1;
                if (cnt == 3'd7) bcd <= sh_nx[19:8];
            end
        end
    end

    always_comb begin
        wrap    = rcnt == RW'(REFRESH_DIV - 1);
        blank_h = LZ_BLANK && bcd[11:8] == 4'd0;
        blank_t = blank_h && bcd[7:4] == 4'd0;
        digit   = idx == 2'd0 ? bcd[3:0] : idx == 2'd1 ? bcd[7:4] : bcd[11:8];
        lit     = (idx == 2'd0) | (idx == 2'd1 & !blank_t) | (idx == 2'd2 & !blank_h);
        an_nx   = lit ? ~(4'b0001 << idx) : 4'hF;
        seg_nx  = lit ? seg_code(digit) : 7'h7F;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcnt <= '0;
            idx  <= '0;
            seg  <= 7'h7F;
            an   <= 4'hF;
        end else begin
            rcnt <= wrap ? '0 : rcnt + RW'(1);
            idx  <= wrap ? idx + 2'd1 : idx;
            seg  <= seg_nx;
            an   <= an_nx;
        end
    end

    assign dp = 1'b1;
endmodule
